mem_port_ctrl: RTL and testbench

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

---
 rtl/mem_port_ctrl_pkg.sv | 35 +++
 rtl/mem_port_ctrl_if.sv | 32 +++
 rtl/mem_port_ctrl_arbiter.sv | 61 ++++++
 rtl/mem_port_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_port_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the two-client memory port
// controller.
//   NUM_CLIENTS   - number of clients sharing the single memory port
//   client_idx_t  - index of one client
//   mem_req_t     - one client request (wen, addr, wdata); its fields are sized
//                   for the widest supported configuration, and a narrower
//                   instance zero-pads the upper bits
//   grant_to_idx  - converts a one-hot grant vector into a client index
package mem_ctrl_pkg;

    localparam int NUM_CLIENTS   = 2;
    localparam int CLIENT_IDX_W  = 1;
    localparam int MAX_WORD_SIZE = 64;
    localparam int MAX_ADDR_SIZE = 64;

    typedef logic [CLIENT_IDX_W-1:0] client_idx_t;

    typedef struct packed {
        logic                     wen;
        logic [MAX_ADDR_SIZE-1:0] addr;
        logic [MAX_WORD_SIZE-1:0] wdata;
    } mem_req_t;

    function automatic client_idx_t grant_to_idx(input logic [NUM_CLIENTS-1:0] grant);
        client_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant[i]) begin
                idx = client_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// mem_port_ctrl_if: request/response handshake between one client and the
// memory port controller.
//   req_valid/req_ready          - request handshake (ready from controller)
//   req_wen/req_addr/req_wdata   - request payload (1 = write)
//   rsp_valid/rsp_ready          - read response handshake (ready from client)
//   rsp_rdata                    - read response data
// Modports: master = client side, slave = controller side.
interface mem_port_ctrl_if #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8
);

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_wen;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_port_ctrl_arbiter.sv
// mem_rr_arbiter: picks at most one of the eligible client requests per cycle.
//   clock, reset - single clock, synchronous active-high reset
//   req          - per-client eligible request vector
//   grant        - one-hot grant (all zero when nothing is granted or in reset)
// Configuration macro MEM_PORT_CTRL_RR_EN: when defined, a contended cycle
// goes to the client that did not win last; otherwise client 0 always wins
// contention. last_grant is tracked in both builds.
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CLIENTS-1:0] req,
    output logic [NUM_CLIENTS-1:0] grant
);

    client_idx_t last_grant;
    client_idx_t last_grant_next;

    // Grant selection: an uncontended request wins outright; contention is
    // resolved by the build-time policy.
    always_comb begin
        grant = '0;
        if (!reset) begin
            if (req[0] && req[1]) begin
`ifdef MEM_PORT_CTRL_RR_EN
                if (last_grant == client_idx_t'(0)) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
`else
                grant = 2'b01;
`endif
            end else begin
                grant = req;
            end
        end
    end

    // last_grant only moves when somebody is actually granted.
    always_comb begin
        last_grant_next = last_grant;
        if (grant[0]) begin
            last_grant_next = client_idx_t'(0);
        end
        if (grant[1]) begin
            last_grant_next = client_idx_t'(1);
        end
    end

    // Reset to 1 so that client 0 is favoured at the first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= client_idx_t'(1);
        end else begin
            last_grant <= last_grant_next;
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: shares one single-port memory between two clients.
//   clock, reset        - single clock, synchronous active-high reset
//   c0, c1              - client request/response interfaces (slave side)
//   mem_wen             - memory write enable
//   mem_addr, mem_wdata - memory address / write data (hold when idle)
//   mem_rdata           - memory read data, combinational from mem_addr
// Writes complete in the grant cycle with no response; reads capture
// mem_rdata at the grant edge and present it one cycle later until consumed.
// Arbitration policy is selected by the MEM_PORT_CTRL_RR_EN macro inside
// mem_rr_arbiter.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_port_ctrl_if.slave       c0,
    mem_port_ctrl_if.slave       c1,
    output logic                 mem_wen,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    mem_req_t               client_req [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] req_valid;
    logic [NUM_CLIENTS-1:0] rsp_ready;
    logic [NUM_CLIENTS-1:0] eligible;
    logic [NUM_CLIENTS-1:0] grant;
    logic [NUM_CLIENTS-1:0] rsp_valid_q;
    logic [WORD_SIZE-1:0]   rsp_rdata_q [NUM_CLIENTS];

    client_idx_t            grant_idx;
    mem_req_t               sel_req;
    logic                   any_grant;
    logic [ADDR_SIZE-1:0]   mem_addr_q;
    logic [WORD_SIZE-1:0]   mem_wdata_q;
    logic                   unused_req_bits;

    // Collect both clients into arrays so the rest of the logic is per-index.
    // A read is only eligible when its response slot is free or being
    // drained this very cycle; writes never produce a response.
    always_comb begin
        req_valid = {c1.req_valid, c0.req_valid};
        rsp_ready = {c1.rsp_ready, c0.rsp_ready};

        client_req[0]                       = '0;
        client_req[0].wen                   = c0.req_wen;
        client_req[0].addr[ADDR_SIZE-1:0]   = c0.req_addr;
        client_req[0].wdata[WORD_SIZE-1:0]  = c0.req_wdata;

        client_req[1]                       = '0;
        client_req[1].wen                   = c1.req_wen;
        client_req[1].addr[ADDR_SIZE-1:0]   = c1.req_addr;
        client_req[1].wdata[WORD_SIZE-1:0]  = c1.req_wdata;

        eligible = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            eligible[i] = req_valid[i] &&
                          (client_req[i].wen || !rsp_valid_q[i] || rsp_ready[i]);
        end
    end

    mem_rr_arbiter u_arbiter (
        .clock (clock),
        .reset (reset),
        .req   (eligible),
        .grant (grant)
    );

    // Memory port drive: the granted request goes straight out; with no
    // grant the address/data stay at whatever was last presented.
    always_comb begin
        any_grant = |grant;
        grant_idx = grant_to_idx(grant);
        sel_req   = client_req[grant_idx];
        mem_wen   = any_grant && sel_req.wen;
        mem_addr  = any_grant ? sel_req.addr[ADDR_SIZE-1:0]  : mem_addr_q;
        mem_wdata = any_grant ? sel_req.wdata[WORD_SIZE-1:0] : mem_wdata_q;
    end

    // Upper struct bits are zero padding for narrow configurations.
    assign unused_req_bits = ^sel_req;

    assign c0.req_ready = grant[0];
    assign c1.req_ready = grant[1];
    assign c0.rsp_valid = rsp_valid_q[0];
    assign c1.rsp_valid = rsp_valid_q[1];
    assign c0.rsp_rdata = rsp_rdata_q[0];
    assign c1.rsp_rdata = rsp_rdata_q[1];

    // Holding registers behind the idle value of mem_addr/mem_wdata.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (any_grant) begin
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
        end
    end

    // Response slots: a granted read refills the slot even if it is being
    // consumed in the same cycle, so valid stays high with the new word.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (reset) begin
                rsp_valid_q[i] <= 1'b0;
                rsp_rdata_q[i] <= '0;
            end else if (grant[i] && !client_req[i].wen) begin
                rsp_valid_q[i] <= 1'b1;
                rsp_rdata_q[i] <= mem_rdata;
            end else if (rsp_valid_q[i] && rsp_ready[i]) begin
                rsp_valid_q[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed scoreboard bench for mem_port_ctrl.
// The stimulus process pushes expected grants and read data into queues; a
// monitor pops and compares whenever the DUT raises req_ready or a response
// is consumed. Unwritten memory location a holds ~a.
module tb_mem_port_ctrl;

    localparam int WORD_SIZE = 8;
    localparam int ADDR_SIZE = 8;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 mem_wen;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic [WORD_SIZE-1:0] mem [256];

    int checks   = 0;
    int failures = 0;
    int mon_client;

    int                   exp_grant [$];
    logic [WORD_SIZE-1:0] exp_rsp0 [$];
    logic [WORD_SIZE-1:0] exp_rsp1 [$];

    mem_port_ctrl_if #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) c0_if ();
    mem_port_ctrl_if #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) c1_if ();

    mem_port_ctrl #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) dut (
        .clock     (clock),
        .reset     (reset),
        .c0        (c0_if),
        .c1        (c1_if),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    // Single-port memory model: combinational read, write on posedge.
    assign mem_rdata = mem[mem_addr];

    initial begin : memory_model
        for (int i = 0; i < 256; i++) begin
            mem[i] = ~8'(i);
        end
        forever begin
            @(posedge clock);
            if (mem_wen) begin
                mem[mem_addr] <= mem_wdata;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int client, input logic valid, input logic wen,
                                  input logic [ADDR_SIZE-1:0] addr,
                                  input logic [WORD_SIZE-1:0] wdata);
        if (client == 0) begin
            c0_if.req_valid = valid;
            c0_if.req_wen   = wen;
            c0_if.req_addr  = addr;
            c0_if.req_wdata = wdata;
        end else begin
            c1_if.req_valid = valid;
            c1_if.req_wen   = wen;
            c1_if.req_addr  = addr;
            c1_if.req_wdata = wdata;
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every req_ready must match the next expected grant, and every
    // consumed response must match the next expected word for that client.
    always @(negedge clock) begin
        if (c0_if.req_ready && c1_if.req_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL grant_onehot: got both req_ready, expected at most one");
        end else if (c0_if.req_ready || c1_if.req_ready) begin
            mon_client = c1_if.req_ready ? 1 : 0;
            if (exp_grant.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL grant_unexpected: got grant to c%0d, expected none", mon_client);
            end else begin
                check_output("grant_client", 32'(mon_client), 32'(exp_grant.pop_front()));
            end
        end
        if (c0_if.rsp_valid && c0_if.rsp_ready) begin
            if (exp_rsp0.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL c0_rsp_unexpected: got 0x%0h, expected no response", c0_if.rsp_rdata);
            end else begin
                check_output("c0_rsp_rdata", 32'(c0_if.rsp_rdata), 32'(exp_rsp0.pop_front()));
            end
        end
        if (c1_if.rsp_valid && c1_if.rsp_ready) begin
            if (exp_rsp1.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL c1_rsp_unexpected: got 0x%0h, expected no response", c1_if.rsp_rdata);
            end else begin
                check_output("c1_rsp_rdata", 32'(c1_if.rsp_rdata), 32'(exp_rsp1.pop_front()));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "[TB] simulation timed out");
    end

    // Directed stimulus sequence.
    initial begin : stimulus
        reset = 1'b1;
        c0_if.rsp_ready = 1'b1;
        c1_if.rsp_ready = 1'b1;
        apply_stimulus(0, 1'b1, 1'b0, 8'h01, 8'h00);
        apply_stimulus(1, 1'b1, 1'b0, 8'h02, 8'h00);

        // Requests during reset are never granted.
        @(negedge clock);
        check_output("reset_c0_req_ready", 32'(c0_if.req_ready), 0);
        check_output("reset_c1_req_ready", 32'(c1_if.req_ready), 0);
        check_output("reset_mem_wen", 32'(mem_wen), 0);
        next_cycle();
        next_cycle();

        reset = 1'b0;
        apply_stimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        apply_stimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        check_output("post_reset_c0_rsp_valid", 32'(c0_if.rsp_valid), 0);
        check_output("post_reset_c1_rsp_valid", 32'(c1_if.rsp_valid), 0);
        check_output("post_reset_c0_rsp_rdata", 32'(c0_if.rsp_rdata), 0);
        check_output("post_reset_c1_rsp_rdata", 32'(c1_if.rsp_rdata), 0);
        check_output("post_reset_mem_addr", 32'(mem_addr), 0);
        check_output("post_reset_mem_wdata", 32'(mem_wdata), 0);
        check_output("post_reset_last_grant", 32'(dut.u_arbiter.last_grant), 1);
        next_cycle();

        // c0 write 0x10 <= 0xA5, visible on the memory port this cycle.
        apply_stimulus(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        exp_grant.push_back(0);
        @(negedge clock);
        check_output("wr_mem_wen", 32'(mem_wen), 1);
        check_output("wr_mem_addr", 32'(mem_addr), 'h10);
        check_output("wr_mem_wdata", 32'(mem_wdata), 'hA5);
        next_cycle();

        // c1 reads 0x10 the very next cycle and must see the new word.
        apply_stimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        apply_stimulus(1, 1'b1, 1'b0, 8'h10, 8'h00);
        exp_grant.push_back(1);
        exp_rsp1.push_back(8'hA5);
        @(negedge clock);
        check_output("wr_no_c0_rsp", 32'(c0_if.rsp_valid), 0);
        check_output("rd_mem_wen", 32'(mem_wen), 0);
        check_output("rd_mem_addr", 32'(mem_addr), 'h10);
        next_cycle();

        apply_stimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        check_output("rd_latency_c1_rsp_valid", 32'(c1_if.rsp_valid), 1);
        check_output("idle_mem_wen", 32'(mem_wen), 0);
        check_output("idle_mem_addr_hold", 32'(mem_addr), 'h10);
        next_cycle();

        @(negedge clock);
        check_output("consumed_c1_rsp_valid", 32'(c1_if.rsp_valid), 0);
        next_cycle();

        // Both clients read continuously with rsp_ready held high.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(0, 1'b1, 1'b0, 8'h20, 8'h00);
            apply_stimulus(1, 1'b1, 1'b0, 8'h30, 8'h00);
`ifdef MEM_PORT_CTRL_RR_EN
            if (k % 2 == 0) begin
                exp_grant.push_back(0);
                exp_rsp0.push_back(8'hDF);
            end else begin
                exp_grant.push_back(1);
                exp_rsp1.push_back(8'hCF);
            end
`else
            exp_grant.push_back(0);
            exp_rsp0.push_back(8'hDF);
`endif
            next_cycle();
        end
        apply_stimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        apply_stimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
        next_cycle();
        @(negedge clock);
        check_output("drained_c0_rsp_valid", 32'(c0_if.rsp_valid), 0);
        check_output("drained_c1_rsp_valid", 32'(c1_if.rsp_valid), 0);
        next_cycle();

        // c0 response held while c0 keeps asking: reads blocked, writes pass.
        c0_if.rsp_ready = 1'b0;
        apply_stimulus(0, 1'b1, 1'b0, 8'h40, 8'h00);
        exp_grant.push_back(0);
        exp_rsp0.push_back(8'hBF);
        next_cycle();

        apply_stimulus(0, 1'b1, 1'b0, 8'h41, 8'h00);
        @(negedge clock);
        check_output("blocked_rd_c0_req_ready", 32'(c0_if.req_ready), 0);
        check_output("held_c0_rsp_valid", 32'(c0_if.rsp_valid), 1);
        check_output("held_c0_rsp_rdata", 32'(c0_if.rsp_rdata), 'hBF);
        check_output("blocked_rd_mem_wen", 32'(mem_wen), 0);
        next_cycle();

        apply_stimulus(0, 1'b1, 1'b1, 8'h41, 8'h5A);
        exp_grant.push_back(0);
        @(negedge clock);
        check_output("window_wr_mem_wen", 32'(mem_wen), 1);
        check_output("window_wr_mem_addr", 32'(mem_addr), 'h41);
        next_cycle();

        apply_stimulus(0, 1'b1, 1'b0, 8'h41, 8'h00);
        @(negedge clock);
        check_output("blocked_rd2_c0_req_ready", 32'(c0_if.req_ready), 0);
        check_output("held2_c0_rsp_rdata", 32'(c0_if.rsp_rdata), 'hBF);
        next_cycle();

        c0_if.rsp_ready = 1'b1;
        exp_grant.push_back(0);
        exp_rsp0.push_back(8'h5A);
        next_cycle();

        apply_stimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        check_output("refill_c0_rsp_valid", 32'(c0_if.rsp_valid), 1);
        next_cycle();

        // Pending c1 response discarded by reset; last_grant back to 1.
        c1_if.rsp_ready = 1'b0;
        apply_stimulus(1, 1'b1, 1'b0, 8'h50, 8'h00);
        exp_grant.push_back(1);
        next_cycle();

        apply_stimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
        apply_stimulus(0, 1'b1, 1'b1, 8'h61, 8'h33);
        exp_grant.push_back(0);
        next_cycle();

        reset = 1'b1;
        apply_stimulus(0, 1'b1, 1'b1, 8'h60, 8'h77);
        @(negedge clock);
        check_output("pending_c1_rsp_valid", 32'(c1_if.rsp_valid), 1);
        check_output("pending_c1_rsp_rdata", 32'(c1_if.rsp_rdata), 'hAF);
        check_output("pre_reset_last_grant", 32'(dut.u_arbiter.last_grant), 0);
        check_output("in_reset_mem_wen", 32'(mem_wen), 0);
        check_output("in_reset_c0_req_ready", 32'(c0_if.req_ready), 0);
        next_cycle();

        reset = 1'b0;
        c1_if.rsp_ready = 1'b1;
        apply_stimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        check_output("discard_c1_rsp_valid", 32'(c1_if.rsp_valid), 0);
        check_output("rereset_last_grant", 32'(dut.u_arbiter.last_grant), 1);
        check_output("rereset_mem_wen", 32'(mem_wen), 0);
        check_output("rereset_mem_addr", 32'(mem_addr), 0);
        next_cycle();

        check_output("grant_queue_empty", 32'(exp_grant.size()), 0);
        check_output("c0_rsp_queue_empty", 32'(exp_rsp0.size()), 0);
        check_output("c1_rsp_queue_empty", 32'(exp_rsp1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
